// File: rtl/sample_sequencer.sv
// Per-sample scheduler for the ADC -> processor -> DAC audio path: sample tick,
// transaction sequencing, shared SCK arbitration and overrun/timeout status.
module sample_sequencer #(
  parameter int unsigned TICK_PERIOD  = 5000,
  parameter int unsigned ADC_TIMEOUT  = 2047,
  parameter int unsigned PROC_TIMEOUT = 255,
  parameter int unsigned DAC_CYCLES   = 40,
  localparam int unsigned DATA_W      = 10,
  localparam int unsigned CNT_W       = 8
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        ch_mode,
  input  logic              clr_status,
  output logic              adc_start,
  output logic              adc_channel,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] proc_data,
  output logic              proc_valid,
  input  logic              proc_done,
  input  logic [DATA_W-1:0] proc_result,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_load,
  output logic              sck_sel,
  output logic              busy,
  output logic              overrun,
  output logic              timeout,
  output logic [CNT_W-1:0]  overrun_cnt
);

  localparam int unsigned TICK_W   = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int unsigned AP_MAX   = (ADC_TIMEOUT > PROC_TIMEOUT) ? ADC_TIMEOUT : PROC_TIMEOUT;
  localparam int unsigned WAIT_MAX = (AP_MAX > DAC_CYCLES) ? AP_MAX : DAC_CYCLES;
  localparam int unsigned WAIT_W   = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADC_START,
    S_ADC_WAIT,
    S_PROC_START,
    S_PROC_WAIT,
    S_DAC_LOAD,
    S_DAC_WAIT
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [TICK_W-1:0] tick_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              tick;
  logic              toggle;
  logic              adc_hit;
  logic              proc_hit;
  logic              adc_expired;
  logic              proc_expired;
  logic              overrun_ev;
  logic              timeout_ev;

  logic              adc_start_d;
  logic              adc_channel_d;
  logic              proc_valid_d;
  logic              dac_load_d;
  logic              sck_sel_d;
  logic              busy_d;
  logic              overrun_d;
  logic              timeout_d;
  logic              toggle_d;
  logic [DATA_W-1:0] proc_data_d;
  logic [DATA_W-1:0] dac_data_d;
  logic [CNT_W-1:0]  overrun_cnt_d;

  assign tick         = enable && (tick_cnt == TICK_W'(TICK_PERIOD - 1));
  assign adc_hit      = (state == S_ADC_WAIT) && adc_valid;
  assign proc_hit     = (state == S_PROC_WAIT) && proc_done;
  assign adc_expired  = (state == S_ADC_WAIT) && !adc_valid && (wait_cnt == WAIT_W'(ADC_TIMEOUT));
  assign proc_expired = (state == S_PROC_WAIT) && !proc_done && (wait_cnt == WAIT_W'(PROC_TIMEOUT));
  assign timeout_ev   = adc_expired || proc_expired;
  assign overrun_ev   = tick && (state != S_IDLE);

  // Sample tick counter; held at zero while sampling is disabled
  always_ff @(posedge sysclk) begin
    if (reset || !enable || tick) tick_cnt <= '0;
    else                          tick_cnt <= tick_cnt + TICK_W'(1);
  end

  // Cycles spent in the current state; restarts on every state change
  always_ff @(posedge sysclk) begin
    if (reset || (next_state != state) || (state == S_IDLE)) wait_cnt <= '0;
    else                                                     wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  always_ff @(posedge sysclk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:       if (tick) next_state = S_ADC_START;
      S_ADC_START:  next_state = S_ADC_WAIT;
      S_ADC_WAIT: begin
        if (adc_valid)        next_state = S_PROC_START;
        else if (adc_expired) next_state = S_IDLE;
      end
      S_PROC_START: next_state = S_PROC_WAIT;
      S_PROC_WAIT: begin
        if (proc_done)         next_state = S_DAC_LOAD;
        else if (proc_expired) next_state = S_IDLE;
      end
      S_DAC_LOAD:   next_state = S_DAC_WAIT;
      S_DAC_WAIT:   if (wait_cnt == WAIT_W'(DAC_CYCLES - 1)) next_state = S_IDLE;
      default:      next_state = S_IDLE;
    endcase
  end

  // Output decode from next_state so the registered outputs line up with the state
  always_comb begin
    adc_start_d   = (next_state == S_ADC_START);
    proc_valid_d  = (next_state == S_PROC_START);
    dac_load_d    = (next_state == S_DAC_LOAD);
    sck_sel_d     = (next_state == S_DAC_LOAD) || (next_state == S_DAC_WAIT);
    busy_d        = (next_state != S_IDLE);
    adc_channel_d = adc_channel;
    toggle_d      = toggle;
    proc_data_d   = proc_data;
    dac_data_d    = dac_data;
    overrun_d     = overrun;
    timeout_d     = timeout;
    overrun_cnt_d = overrun_cnt;

    if ((state == S_IDLE) && (next_state == S_ADC_START)) begin
      if (ch_mode == 2'd0)      adc_channel_d = 1'b0;
      else if (ch_mode == 2'd1) adc_channel_d = 1'b1;
      else                      adc_channel_d = toggle;
    end
    if (adc_hit) begin
      proc_data_d = adc_data;
      toggle_d    = !toggle;
    end
    if (proc_hit) dac_data_d = proc_result;

    // Clear first so a same-cycle event still registers
    if (clr_status) begin
      overrun_d     = 1'b0;
      timeout_d     = 1'b0;
      overrun_cnt_d = '0;
    end
    if (overrun_ev) begin
      overrun_d = 1'b1;
      if (overrun_cnt_d != '1) overrun_cnt_d = overrun_cnt_d + CNT_W'(1);
    end
    if (timeout_ev) timeout_d = 1'b1;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      adc_start   <= 1'b0;
      adc_channel <= 1'b0;
      proc_valid  <= 1'b0;
      dac_load    <= 1'b0;
      sck_sel     <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
      toggle      <= 1'b0;
      proc_data   <= '0;
      dac_data    <= '0;
      overrun_cnt <= '0;
    end else begin
      adc_start   <= adc_start_d;
      adc_channel <= adc_channel_d;
      proc_valid  <= proc_valid_d;
      dac_load    <= dac_load_d;
      sck_sel     <= sck_sel_d;
      busy        <= busy_d;
      overrun     <= overrun_d;
      timeout     <= timeout_d;
      toggle      <= toggle_d;
      proc_data   <= proc_data_d;
      dac_data    <= dac_data_d;
      overrun_cnt <= overrun_cnt_d;
    end
  end

endmodule
